fetch_queue: RTL

- Next-generation instruction fetch stage that decouples icache latency from decode.
- Owns the PC and keeps up to MAX_INFLIGHT icache requests outstanding with a valid/ready request channel.
- Buffers returned instructions, tagged with their PC, in a QUEUE_DEPTH-entry FIFO drained by decode through valid/ready.
- Redirects (branch, trap, flush) discard queued and in-flight work without stalling for the icache to drain.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_queue.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch stage: queued entry layout, fetch state
// and the default reset fetch address.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        error;
  } FetchEntry;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } FetchState;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO with synchronous clear; the head reads as zero
// while empty so downstream outputs stay quiet.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr_i && do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr_i && push_i) assert (do_push);
  end

  assign data_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, keeps icache requests in flight and
// buffers tagged instructions for decode; redirects discard work without draining.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_inst,
  input  logic        ic_resp_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_error
);

  localparam int unsigned CW  = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned QCW = $clog2(QUEUE_DEPTH + 1);

  FetchState      state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  kill_q, kill_d;
  logic [CW-1:0]  tag_cnt;
  logic [QCW-1:0] q_count;
  logic [31:0]    tag_pc;
  logic [31:0]    in_use, q_claim;
  logic           req_fire, resp_live, q_push, q_pop;
  logic [$bits(FetchEntry)-1:0] q_rdata;
  FetchEntry      q_wentry, head;

  assign req_fire  = ic_req_valid && ic_req_ready;
  // Responses return in order, so any pending kills belong to the oldest requests.
  assign resp_live = ic_resp_valid && (kill_q == '0);
  assign q_push    = resp_live && !redirect_valid;
  assign q_pop     = out_valid && out_ready;
  assign in_use    = 32'(inflight_q) + 32'(kill_q);
  assign q_claim   = 32'(q_count) + 32'(inflight_q);
  assign q_wentry  = '{pc: tag_pc, inst: ic_resp_inst, error: ic_resp_error};
  assign head      = FetchEntry'(q_rdata);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    kill_d       = kill_q;
    ic_req_valid = !rst && (state_q == RUN) && !redirect_valid &&
                   (in_use < MAX_INFLIGHT) && (q_claim < QUEUE_DEPTH);
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'd3;
      state_d    = RUN;
      inflight_d = '0;
      kill_d     = CW'(32'(kill_q) + 32'(inflight_q) - 32'(ic_resp_valid));
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      inflight_d = CW'(32'(inflight_q) + 32'(req_fire) - 32'(resp_live));
      if (ic_resp_valid && !resp_live) kill_d = kill_q - CW'(1);
      if (resp_live && ic_resp_error) state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      kill_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && resp_live) assert (tag_cnt != '0);
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_INFLIGHT)) u_tags (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (redirect_valid),
    .push_i (req_fire),
    .data_i (pc_q),
    .pop_i  (resp_live),
    .data_o (tag_pc),
    .count_o(tag_cnt)
  );

  fetch_fifo #(.WIDTH($bits(FetchEntry)), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (redirect_valid),
    .push_i (q_push),
    .data_i (q_wentry),
    .pop_i  (q_pop),
    .data_o (q_rdata),
    .count_o(q_count)
  );

  assign ic_req_addr = pc_q;
  assign out_valid   = !rst && (q_count != '0);
  assign out_pc      = out_valid ? head.pc   : '0;
  assign out_inst    = out_valid ? head.inst : '0;
  assign out_error   = out_valid ? head.error : 1'b0;

endmodule
